// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter of three write ports onto one registered register-file write port
module wb_port_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [3*DATA_W-1:0]   req_data,
   input  logic                  freeze,
   output logic [2:0]            gnt,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic [2**ADDR_W-1:0]  wr_sel,
   output logic [7:0]            conflict_cnt
);
   localparam int SEL_W = 2**ADDR_W;
   logic [1:0]        ptr;
   logic [1:0]        ptr_nxt;
   logic [2:0]        g0, g1, g2;
   logic              any;
   logic              contend;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   // first requester in ptr order wins; illegal ptr 3 searches like ptr 0
   always_comb begin
      g0      = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      g1      = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      g2      = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      gnt     = (!rst_n || freeze) ? 3'b000 : ptr == 2'd1 ? g1 : ptr == 2'd2 ? g2 : g0;
      any     = |gnt;
      contend = !freeze && ((req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]));
      g_addr  = gnt[2] ? req_addr[2*ADDR_W +: ADDR_W] : gnt[1] ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
      g_data  = gnt[2] ? req_data[2*DATA_W +: DATA_W] : gnt[1] ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
      ptr_nxt = any ? (gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0) : (ptr == 2'd3 ? 2'd0 : ptr);
   end
   // pointer, write register and saturating contention counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr          <= 2'd0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_sel       <= '0;
         conflict_cnt <= 8'd0;
      end else begin
         ptr          <= ptr_nxt;
         wr_en        <= any;
         wr_sel       <= any ? SEL_W'(1) << g_addr : '0;
         conflict_cnt <= (contend && conflict_cnt != 8'hFF) ? conflict_cnt + 8'd1 : conflict_cnt;
         if (any) begin
            wr_addr <= g_addr;
            wr_data <= g_data;
         end
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table plus reset and saturation sequences for wb_port_arbiter
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = 3'b000;
   logic [8:0]  req_addr = '0;
   logic [47:0] req_data = '0;
   logic        freeze = 1'b0;
   logic [2:0]  gnt;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [7:0]  wr_sel;
   logic [7:0]  conflict_cnt;
   int          total = 0;
   int          passed = 0;

   typedef struct {
      logic [2:0]  req;
      logic        frz;
      logic [2:0]  a0, a1, a2;
      logic [15:0] d0, d1, d2;
      logic [2:0]  eg;
      logic        ee;
      logic [2:0]  ea;
      logic [15:0] ed;
      logic [7:0]  ec;
   } vec_t;

   vec_t vecs[$];

   wb_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
      .freeze(freeze), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_sel(wr_sel), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_wr(input string tag, input logic ee, input logic [2:0] ea, input logic [15:0] ed, input logic [7:0] ec);
      logic [7:0] es;
      es = ee ? (8'b1 << ea) : 8'b0;
      chk({tag, " wr_en"}, 64'(wr_en), 64'(ee));
      chk({tag, " wr_addr"}, 64'(wr_addr), 64'(ea));
      chk({tag, " wr_data"}, 64'(wr_data), 64'(ed));
      chk({tag, " wr_sel"}, 64'(wr_sel), 64'(es));
      chk({tag, " conflict_cnt"}, 64'(conflict_cnt), 64'(ec));
   endtask

   initial begin
      vecs.push_back('{3'b001, 1'b0, 3'd5, 3'd2, 3'd4, 16'hABCD, 16'h2222, 16'h4444, 3'b001, 1'b1, 3'd5, 16'hABCD, 8'd0});
      vecs.push_back('{3'b000, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b000, 1'b0, 3'd5, 16'hABCD, 8'd0});
      vecs.push_back('{3'b101, 1'b0, 3'd3, 3'd2, 3'd3, 16'hAAAA, 16'h2222, 16'hCCCC, 3'b100, 1'b1, 3'd3, 16'hCCCC, 8'd1});
      vecs.push_back('{3'b101, 1'b0, 3'd3, 3'd2, 3'd3, 16'hAAAA, 16'h2222, 16'hCCCC, 3'b001, 1'b1, 3'd3, 16'hAAAA, 8'd2});
      vecs.push_back('{3'b010, 1'b0, 3'd1, 3'd6, 3'd4, 16'h1111, 16'h6666, 16'h4444, 3'b010, 1'b1, 3'd6, 16'h6666, 8'd2});
      vecs.push_back('{3'b100, 1'b0, 3'd1, 3'd2, 3'd7, 16'h1111, 16'h2222, 16'h7777, 3'b100, 1'b1, 3'd7, 16'h7777, 8'd2});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b001, 1'b1, 3'd1, 16'h1111, 8'd3});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b010, 1'b1, 3'd2, 16'h2222, 8'd4});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b100, 1'b1, 3'd4, 16'h4444, 8'd5});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b001, 1'b1, 3'd1, 16'h1111, 8'd6});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b010, 1'b1, 3'd2, 16'h2222, 8'd7});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b100, 1'b1, 3'd4, 16'h4444, 8'd8});
      for (int i = 0; i < 4; i++)
         vecs.push_back('{3'b111, 1'b1, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b000, 1'b0, 3'd4, 16'h4444, 8'd8});
      vecs.push_back('{3'b111, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b001, 1'b1, 3'd1, 16'h1111, 8'd9});
      vecs.push_back('{3'b110, 1'b0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b010, 1'b1, 3'd2, 16'h2222, 8'd10});
      vecs.push_back('{3'b000, 1'b1, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444, 3'b000, 1'b0, 3'd2, 16'h2222, 8'd10});

      req = 3'b111;
      req_addr = {3'd4, 3'd2, 3'd1};
      req_data = {16'h4444, 16'h2222, 16'h1111};
      #12;
      chk("reset gnt", 64'(gnt), 64'(3'b000));
      chk_wr("reset", 1'b0, 3'd0, 16'h0000, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 3'b000;

      foreach (vecs[i]) begin
         @(negedge clk);
         req = vecs[i].req;
         freeze = vecs[i].frz;
         req_addr = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
         req_data = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
         #1;
         chk($sformatf("vec%0d gnt", i), 64'(gnt), 64'(vecs[i].eg));
         @(posedge clk);
         #1;
         chk_wr($sformatf("vec%0d", i), vecs[i].ee, vecs[i].ea, vecs[i].ed, vecs[i].ec);
      end

      @(negedge clk);
      freeze = 1'b0;
      req = 3'b011;
      req_addr = {3'd4, 3'd2, 3'd1};
      req_data = {16'h4444, 16'h2222, 16'h1111};
      for (int i = 0; i < 300; i++) begin
         #1;
         chk($sformatf("sat%0d gnt", i), 64'(gnt), 64'(i % 2 == 0 ? 3'b001 : 3'b010));
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d cnt", i), 64'(conflict_cnt), 64'(11 + i > 255 ? 255 : 11 + i));
         @(negedge clk);
      end

      req = 3'b001;
      #1;
      chk("pre-reset gnt", 64'(gnt), 64'(3'b001));
      @(posedge clk);
      #1;
      chk_wr("pre-reset", 1'b1, 3'd1, 16'h1111, 8'd255);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async gnt", 64'(gnt), 64'(3'b000));
      chk_wr("async", 1'b0, 3'd0, 16'h0000, 8'd0);
      @(negedge clk);
      req = 3'b110;
      #1;
      chk("held reset gnt", 64'(gnt), 64'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-reset gnt", 64'(gnt), 64'(3'b010));
      @(posedge clk);
      #1;
      chk_wr("post-reset", 1'b1, 3'd2, 16'h2222, 8'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
